// File: rtl/la_wb_pkg.sv
// Shared types and constants for the logic-analyzer Wishbone initiator.
package la_wb_pkg;

  localparam int unsigned WB_ADR_W           = 32;
  localparam int unsigned WB_DAT_W           = 32;
  localparam int unsigned WB_SEL_W           = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/la_wb_timeout.sv
// Saturating BUS-cycle counter; o_expired_c flags the last allowed BUS cycle.
module la_wb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired_c
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // r_cnt holds the BUS cycles already elapsed, so this cycle is number r_cnt+1
  assign o_expired_c = (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/la_wb_initiator.sv
// Single-transfer Wishbone classic initiator driven by a cmd/rsp handshake.
// Define LA_WB_TIMEOUT_EN to abort BUS cycles that see no ack within TIMEOUT_CYCLES.
module la_wb_initiator
  import la_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  output logic [CNT_W-1:0]    txn_count
);

  if ((TIMEOUT_CYCLES == 0) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("la_wb_initiator: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t              r_state, w_state_nxt;
  logic                r_cmd_ready, w_cmd_ready_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [WB_DAT_W-1:0] r_rsp_dat, w_rsp_dat_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
  logic                r_cyc, w_cyc_nxt;
  logic                r_stb, w_stb_nxt;
  logic                r_we, w_we_nxt;
  logic [WB_SEL_W-1:0] r_sel, w_sel_nxt;
  logic [WB_ADR_W-1:0] r_adr, w_adr_nxt;
  logic [WB_DAT_W-1:0] r_dat, w_dat_nxt;
  logic [CNT_W-1:0]    r_txn, w_txn_nxt;
  logic                w_expired;

`ifdef LA_WB_TIMEOUT_EN
  logic w_tmo_clr;
  logic w_tmo_en;

  la_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk       (wb_clk_i),
    .i_rst       (wb_rst_i),
    .i_clr       (w_tmo_clr),
    .i_en        (w_tmo_en),
    .o_expired_c (w_expired)
  );

  assign w_tmo_clr = (r_state == IDLE) && cmd_valid;
  assign w_tmo_en  = (r_state == BUS) && !wbm_ack_i;
`else
  assign w_expired = 1'b0;
`endif

  // Next-state and next-output logic; ack beats a simultaneous timeout
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = r_cmd_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_cyc_nxt       = r_cyc;
    w_stb_nxt       = r_stb;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_txn_nxt       = r_txn;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_we_nxt        = cmd_we;
          w_sel_nxt       = cmd_sel;
          w_adr_nxt       = cmd_adr;
          w_dat_nxt       = cmd_dat;
          w_cyc_nxt       = 1'b1;
          w_stb_nxt       = 1'b1;
          w_cmd_ready_nxt = 1'b0;
          w_state_nxt     = BUS;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          w_rsp_dat_nxt   = r_we ? '0 : wbm_dat_i;
          w_rsp_err_nxt   = 1'b0;
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end else if (w_expired) begin
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_cyc_nxt       = 1'b0;
          w_stb_nxt       = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_cmd_ready_nxt = 1'b1;
          w_txn_nxt       = r_txn + CNT_W'(1);
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_cyc_nxt       = 1'b0;
        w_stb_nxt       = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_cmd_ready_nxt = 1'b1;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_txn       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_cyc       <= w_cyc_nxt;
      r_stb       <= w_stb_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_txn       <= w_txn_nxt;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign txn_count = r_txn;

endmodule
